// File: rtl/dma_xfer_sequencer_pkg.sv
// Shared types and default sizes for the DMA transfer sequencer.
// The state, mode and transfer-type encodings used by the FSM and its decode logic.
package dma_xfer_sequencer_pkg;

  localparam int DMA_NCH    = 4;
  localparam int DMA_ADDR_W = 16;
  localparam int DMA_CNT_W  = 16;

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4, SC} xfer_state_t;

  typedef enum logic [1:0] {
    DEMAND  = 2'b00,
    SINGLE  = 2'b01,
    BLOCK   = 2'b10,
    CASCADE = 2'b11
  } mode_t;

  // 2'b11 is an illegal type in the mode register and behaves as verify.
  typedef enum logic [1:0] {
    VERIFY  = 2'b00,
    WRITE   = 2'b01,
    READ    = 2'b10,
    ILLEGAL = 2'b11
  } xfer_t;

endpackage

// File: rtl/dma_xfer_sequencer_if.sv
// Arbiter, register-file and CPU bus signals of the DMA transfer sequencer.
// master = sequencer side, slave = surrounding arbiter/register file/bus side.
interface dma_xfer_sequencer_if
  import dma_xfer_sequencer_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int CNT_W  = DMA_CNT_W,
  parameter int NCH    = DMA_NCH
);
  localparam int CH_W = $clog2(NCH);

  logic              req_valid;
  logic [CH_W-1:0]   req_ch;
  logic [1:0]        mode;
  logic [1:0]        xfer_type;
  logic              addr_dec;
  logic              autoinit;
  logic              dreq_active;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  cur_cnt;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  base_cnt;
  logic              HLDA;
  logic              EOP_N_in;

  logic              HRQ;
  logic              dack_valid;
  logic [CH_W-1:0]   dack_ch;
  logic [ADDR_W-1:0] ADDR;
  logic              ADSTB;
  logic              MEMR_N;
  logic              MEMW_N;
  logic              IOR_N;
  logic              IOW_N;
  logic              EOP_N_out;
  logic              upd_en;
  logic [ADDR_W-1:0] upd_addr;
  logic [CNT_W-1:0]  upd_cnt;
  logic [NCH-1:0]    tc_set;
  logic [NCH-1:0]    mask_set;
  logic              busy;

  modport master (
    input  req_valid, req_ch, mode, xfer_type, addr_dec, autoinit, dreq_active,
           cur_addr, cur_cnt, base_addr, base_cnt, HLDA, EOP_N_in,
    output HRQ, dack_valid, dack_ch, ADDR, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N,
           EOP_N_out, upd_en, upd_addr, upd_cnt, tc_set, mask_set, busy
  );

  modport slave (
    output req_valid, req_ch, mode, xfer_type, addr_dec, autoinit, dreq_active,
           cur_addr, cur_cnt, base_addr, base_cnt, HLDA, EOP_N_in,
    input  HRQ, dack_valid, dack_ch, ADDR, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N,
           EOP_N_out, upd_en, upd_addr, upd_cnt, tc_set, mask_set, busy
  );

endinterface

// File: rtl/dma_xfer_sequencer_addr_cnt_step.sv
// Combinational next address/count for one transfer, with autoinit reload and TC detect.
// Zero latency; both address and count wrap modulo their width.
module dma_xfer_sequencer_addr_cnt_step #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              dec_i,
  input  logic              reload_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  base_cnt_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              tc_o
);

  always_comb begin
    tc_o   = (cnt_i == '0);
    addr_o = dec_i ? (addr_i - ADDR_W'(1)) : (addr_i + ADDR_W'(1));
    cnt_o  = cnt_i - CNT_W'(1);
    if (reload_i) begin
      addr_o = base_addr_i;
      cnt_o  = base_cnt_i;
    end
  end

endmodule

// File: rtl/dma_xfer_sequencer.sv
// 8237-style transfer sequencer: HRQ/HLDA handshake, SI->S0->S1..S4 timing, write-back pulses.
// HRQ 1 clk after req_valid, ADSTB 1 clk after HLDA, 4 clk per transfer; HLDA low stalls in S0.
module dma_xfer_sequencer
  import dma_xfer_sequencer_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int CNT_W  = DMA_CNT_W,
  parameter int NCH    = DMA_NCH
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  dma_xfer_sequencer_if.master   bus
);

  localparam int CH_W = $clog2(NCH);

  xfer_state_t     state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  mode_t           mode_q, mode_d;
  xfer_t           type_q, type_d;
  logic            dec_q, dec_d;
  logic            auto_q, auto_d;
  logic            eop_q, eop_d;

  logic [ADDR_W-1:0] nxt_addr;
  logic [CNT_W-1:0]  nxt_cnt;
  logic              tc;
  logic              end_xfer;
  logic              rd_phase;
  logic              wr_phase;

  assign end_xfer = (state_q == S4) && (tc || eop_q);
  assign rd_phase = (state_q == S2) || (state_q == S3);
  assign wr_phase = (state_q == S3);

  dma_xfer_sequencer_addr_cnt_step #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_step (
    .addr_i      (bus.cur_addr),
    .cnt_i       (bus.cur_cnt),
    .dec_i       (dec_q),
    .reload_i    (end_xfer && auto_q),
    .base_addr_i (bus.base_addr),
    .base_cnt_i  (bus.base_cnt),
    .addr_o      (nxt_addr),
    .cnt_o       (nxt_cnt),
    .tc_o        (tc)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= SI;
      ch_q    <= '0;
      mode_q  <= DEMAND;
      type_q  <= VERIFY;
      dec_q   <= 1'b0;
      auto_q  <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mode_q  <= mode_d;
      type_q  <= type_d;
      dec_q   <= dec_d;
      auto_q  <= auto_d;
      eop_q   <= eop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    mode_d  = mode_q;
    type_d  = type_q;
    dec_d   = dec_q;
    auto_d  = auto_q;
    eop_d   = eop_q;
    case (state_q)
      SI: begin
        eop_d = 1'b0;
        // Channel and mode are captured only here and frozen until the next SI.
        if (bus.req_valid) begin
          state_d = S0;
          ch_d    = bus.req_ch;
          mode_d  = mode_t'(bus.mode);
          type_d  = xfer_t'(bus.xfer_type);
          dec_d   = bus.addr_dec;
          auto_d  = bus.autoinit;
        end
      end
      S0: begin
        if (bus.HLDA) begin
          state_d = (mode_q == CASCADE) ? SC : S1;
        end else if (!bus.req_valid) begin
          state_d = SI;
        end
      end
      SC: if (!bus.dreq_active) state_d = SI;
      S1: state_d = S2;
      S2: begin
        state_d = S3;
        if (!bus.EOP_N_in) eop_d = 1'b1;
      end
      S3: begin
        state_d = S4;
        if (!bus.EOP_N_in) eop_d = 1'b1;
      end
      S4: begin
        if (end_xfer || !bus.HLDA) begin
          state_d = SI;
        end else begin
          case (mode_q)
            BLOCK:   state_d = S1;
            DEMAND:  state_d = bus.dreq_active ? S1 : SI;
            default: state_d = SI;
          endcase
        end
      end
      default: state_d = SI;
    endcase
  end

  always_comb begin
    bus.HRQ        = (state_q != SI);
    bus.busy       = (state_q != SI);
    bus.dack_valid = (state_q inside {S1, S2, S3, S4, SC});
    bus.dack_ch    = ch_q;
    bus.ADSTB      = (state_q == S1);
    bus.ADDR       = '0;
    bus.MEMR_N     = 1'b1;
    bus.MEMW_N     = 1'b1;
    bus.IOR_N      = 1'b1;
    bus.IOW_N      = 1'b1;
    bus.EOP_N_out  = 1'b1;
    bus.upd_en     = 1'b0;
    bus.upd_addr   = nxt_addr;
    bus.upd_cnt    = nxt_cnt;
    bus.tc_set     = '0;
    bus.mask_set   = '0;
    if (state_q inside {S1, S2, S3, S4}) bus.ADDR = bus.cur_addr;
    case (type_q)
      WRITE: begin
        bus.IOR_N  = !rd_phase;
        bus.MEMW_N = !wr_phase;
      end
      READ: begin
        bus.MEMR_N = !rd_phase;
        bus.IOW_N  = !wr_phase;
      end
      default: ;
    endcase
    if (state_q == S4) begin
      bus.upd_en = 1'b1;
      if (end_xfer) begin
        bus.EOP_N_out = 1'b0;
        if (tc) bus.tc_set[ch_q] = 1'b1;
        if (!auto_q) bus.mask_set[ch_q] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_xfer_sequencer.sv
// Directed bench for dma_xfer_sequencer: phase-level reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_dma_xfer_sequencer;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_CASC = 2;
  localparam int P_XFER = 3;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  dma_xfer_sequencer_if #(.ADDR_W(16), .CNT_W(16), .NCH(4)) bus ();

  dma_xfer_sequencer #(.ADDR_W(16), .CNT_W(16), .NCH(4)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit run      = 1'b0;

  // Channel register file: preloaded by the bench, written back by the DUT.
  logic [15:0] ra [4];
  logic [15:0] rc [4];
  logic [15:0] ba [4];
  logic [15:0] bc [4];
  logic        ld_en = 1'b0;
  logic [1:0]  ld_ch = 2'd0;
  logic [15:0] ld_a, ld_c, ld_ba, ld_bc;

  always @(posedge CLK) begin
    if (ld_en) begin
      ra[ld_ch] <= ld_a;
      rc[ld_ch] <= ld_c;
      ba[ld_ch] <= ld_ba;
      bc[ld_ch] <= ld_bc;
    end else if (bus.upd_en) begin
      ra[bus.dack_ch] <= bus.upd_addr;
      rc[bus.dack_ch] <= bus.upd_cnt;
    end
  end

  assign bus.cur_addr  = ra[bus.req_ch];
  assign bus.cur_cnt   = rc[bus.req_ch];
  assign bus.base_addr = ba[bus.req_ch];
  assign bus.base_cnt  = bc[bus.req_ch];

  // Reference model: idle / requesting / cascade / transfer tick 1..4.
  int         m_ph   = P_IDLE;
  int         m_tick = 0;
  logic [1:0] m_ch   = 2'd0;
  logic [1:0] m_mode = 2'd0;
  logic [1:0] m_type = 2'd0;
  logic       m_dec  = 1'b0;
  logic       m_auto = 1'b0;
  logic       m_eop  = 1'b0;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_ph   <= P_IDLE;
      m_tick <= 0;
      m_eop  <= 1'b0;
    end else begin
      case (m_ph)
        P_IDLE: begin
          m_eop <= 1'b0;
          if (bus.req_valid) begin
            m_ph   <= P_REQ;
            m_ch   <= bus.req_ch;
            m_mode <= bus.mode;
            m_type <= bus.xfer_type;
            m_dec  <= bus.addr_dec;
            m_auto <= bus.autoinit;
          end
        end
        P_REQ: begin
          if (bus.HLDA) begin
            if (m_mode == 2'b11) m_ph <= P_CASC;
            else begin
              m_ph   <= P_XFER;
              m_tick <= 1;
            end
          end else if (!bus.req_valid) begin
            m_ph <= P_IDLE;
          end
        end
        P_CASC: if (!bus.dreq_active) m_ph <= P_IDLE;
        default: begin
          if (m_tick < 4) begin
            m_tick <= m_tick + 1;
            if ((m_tick == 2 || m_tick == 3) && !bus.EOP_N_in) m_eop <= 1'b1;
          end else if (bus.cur_cnt == 16'h0 || m_eop || !bus.HLDA || m_mode == 2'b01 ||
                       (m_mode == 2'b00 && !bus.dreq_active)) begin
            m_ph  <= P_IDLE;
            m_eop <= 1'b0;
          end else begin
            m_tick <= 1;
          end
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
  endtask

  task automatic cmp_cycle();
    logic        xfer, rd, wr, last, tc, fin;
    logic [3:0]  oh;
    logic [15:0] ea, ec;
    xfer = (m_ph == P_XFER);
    rd   = xfer && (m_tick == 2 || m_tick == 3);
    wr   = xfer && (m_tick == 3);
    last = xfer && (m_tick == 4);
    tc   = (bus.cur_cnt == 16'h0);
    fin  = last && (tc || m_eop);
    oh   = 4'b0001 << m_ch;
    chk("hrq",       32'(bus.HRQ),        32'(m_ph != P_IDLE));
    chk("busy",      32'(bus.busy),       32'(m_ph != P_IDLE));
    chk("dack_vld",  32'(bus.dack_valid), 32'(m_ph == P_CASC || xfer));
    chk("adstb",     32'(bus.ADSTB),      32'(xfer && m_tick == 1));
    chk("addr",      32'(bus.ADDR),       32'(xfer ? bus.cur_addr : 16'h0));
    chk("ior_n",     32'(bus.IOR_N),      32'(!(rd && m_type == 2'b01)));
    chk("memw_n",    32'(bus.MEMW_N),     32'(!(wr && m_type == 2'b01)));
    chk("memr_n",    32'(bus.MEMR_N),     32'(!(rd && m_type == 2'b10)));
    chk("iow_n",     32'(bus.IOW_N),      32'(!(wr && m_type == 2'b10)));
    chk("eop_n_out", 32'(bus.EOP_N_out),  32'(!fin));
    chk("upd_en",    32'(bus.upd_en),     32'(last));
    chk("tc_set",    32'(bus.tc_set),     32'((last && tc) ? oh : 4'h0));
    chk("mask_set",  32'(bus.mask_set),   32'((fin && !m_auto) ? oh : 4'h0));
    if (m_ph == P_CASC || xfer) chk("dack_ch", 32'(bus.dack_ch), 32'(m_ch));
    if (last) begin
      if (fin && m_auto) begin
        ea = bus.base_addr;
        ec = bus.base_cnt;
      end else begin
        ea = m_dec ? bus.cur_addr - 16'd1 : bus.cur_addr + 16'd1;
        ec = bus.cur_cnt - 16'd1;
      end
      chk("upd_addr", 32'(bus.upd_addr), 32'(ea));
      chk("upd_cnt",  32'(bus.upd_cnt),  32'(ec));
    end
  endtask

  always @(negedge CLK) if (run && RESET_N) cmp_cycle();

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input logic [1:0] ch, input logic [15:0] a, input logic [15:0] c,
                      input logic [15:0] b_a, input logic [15:0] b_c);
    ld_en = 1'b1; ld_ch = ch; ld_a = a; ld_c = c; ld_ba = b_a; ld_bc = b_c;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic request(input logic [1:0] ch, input logic [1:0] md, input logic [1:0] ty,
                         input logic dec, input logic au);
    bus.req_ch = ch; bus.mode = md; bus.xfer_type = ty;
    bus.addr_dec = dec; bus.autoinit = au;
    bus.dreq_active = 1'b1;
    bus.req_valid   = 1'b1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 20) begin
      tick();
      k++;
    end
    chk("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_ch = 2'd0; bus.mode = 2'd0; bus.xfer_type = 2'd0;
    bus.addr_dec = 1'b0; bus.autoinit = 1'b0; bus.dreq_active = 1'b0;
    bus.HLDA = 1'b0; bus.EOP_N_in = 1'b1;
    RESET_N = 1'b1;
    #1 RESET_N = 1'b0;
    #1;
    chk("rst_hrq",   32'(bus.HRQ), 32'd0);
    chk("rst_dack",  32'(bus.dack_valid), 32'd0);
    chk("rst_dch",   32'(bus.dack_ch), 32'd0);
    chk("rst_addr",  32'(bus.ADDR), 32'd0);
    chk("rst_adstb", 32'(bus.ADSTB), 32'd0);
    chk("rst_strb",  32'({bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N}), 32'hF);
    chk("rst_eop",   32'(bus.EOP_N_out), 32'd1);
    chk("rst_upd",   32'(bus.upd_en), 32'd0);
    chk("rst_tc",    32'(bus.tc_set), 32'd0);
    chk("rst_mask",  32'(bus.mask_set), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    tick();
    RESET_N = 1'b1;
    run = 1'b1;

    // 1: single write ch2, HLDA two clocks after HRQ
    load(2'd2, 16'h1000, 16'h0002, 16'h0, 16'h0);
    request(2'd2, 2'b01, 2'b01, 1'b0, 1'b0);
    tick();
    chk("t1_hrq_lat", 32'(bus.HRQ), 32'd1);
    ticks(2);
    bus.HLDA = 1'b1;
    tick();
    chk("t1_adstb", 32'(bus.ADSTB), 32'd1);
    chk("t1_addr",  32'(bus.ADDR), 32'h1000);
    chk("t1_dch",   32'(bus.dack_ch), 32'd2);
    bus.req_valid = 1'b0; bus.dreq_active = 1'b0;
    tick();
    chk("t1_s2_strb", 32'({bus.IOR_N, bus.MEMW_N}), 32'b01);
    tick();
    chk("t1_s3_strb", 32'({bus.IOR_N, bus.MEMW_N}), 32'b00);
    tick();
    chk("t1_upd_en",   32'(bus.upd_en), 32'd1);
    chk("t1_upd_addr", 32'(bus.upd_addr), 32'h1001);
    chk("t1_upd_cnt",  32'(bus.upd_cnt), 32'h0001);
    tick();
    chk("t1_hrq_off", 32'(bus.HRQ), 32'd0);
    bus.HLDA = 1'b0;
    wait_idle();

    // 2: block read ch0, decrementing across 0000 -> FFFF, terminal count
    load(2'd0, 16'h0000, 16'h0001, 16'h0, 16'h0);
    request(2'd0, 2'b10, 2'b10, 1'b1, 1'b0);
    tick();
    bus.HLDA = 1'b1;
    tick();
    chk("t2_addr0", 32'(bus.ADDR), 32'h0000);
    ticks(2);
    chk("t2_s3_strb", 32'({bus.MEMR_N, bus.IOW_N}), 32'b00);
    tick();
    chk("t2_upd_addr", 32'(bus.upd_addr), 32'hFFFF);
    chk("t2_eop_first", 32'(bus.EOP_N_out), 32'd1);
    tick();
    chk("t2_addr1", 32'(bus.ADDR), 32'hFFFF);
    bus.req_valid = 1'b0;
    ticks(3);
    chk("t2_eop",  32'(bus.EOP_N_out), 32'd0);
    chk("t2_tc",   32'(bus.tc_set), 32'b0001);
    chk("t2_mask", 32'(bus.mask_set), 32'b0001);
    tick();
    chk("t2_hrq_off", 32'(bus.HRQ), 32'd0);
    bus.HLDA = 1'b0;
    wait_idle();

    // 3: demand write ch1, DREQ drops in the third transfer
    load(2'd1, 16'h0500, 16'h0010, 16'h0, 16'h0);
    request(2'd1, 2'b00, 2'b01, 1'b0, 1'b0);
    tick();
    bus.HLDA = 1'b1;
    ticks(5);
    chk("t3_addr2", 32'(bus.ADDR), 32'h0501);
    ticks(4);
    chk("t3_addr3", 32'(bus.ADDR), 32'h0502);
    bus.dreq_active = 1'b0; bus.req_valid = 1'b0;
    ticks(3);
    chk("t3_upd_cnt", 32'(bus.upd_cnt), 32'h000D);
    chk("t3_tc",      32'(bus.tc_set), 32'd0);
    tick();
    chk("t3_busy_off", 32'(bus.busy), 32'd0);
    bus.HLDA = 1'b0;
    wait_idle();

    // 4: block, illegal type (verify), autoinit ch3, external EOP in S2
    load(2'd3, 16'h2100, 16'h0010, 16'h2000, 16'h0003);
    request(2'd3, 2'b10, 2'b11, 1'b0, 1'b1);
    tick();
    bus.HLDA = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.EOP_N_in = 1'b0;
    chk("t4_s2_strb", 32'({bus.MEMR_N, bus.IOR_N}), 32'b11);
    tick();
    bus.EOP_N_in = 1'b1;
    chk("t4_s3_strb", 32'({bus.MEMW_N, bus.IOW_N}), 32'b11);
    tick();
    chk("t4_eop",      32'(bus.EOP_N_out), 32'd0);
    chk("t4_upd_addr", 32'(bus.upd_addr), 32'h2000);
    chk("t4_upd_cnt",  32'(bus.upd_cnt), 32'h0003);
    chk("t4_tc",       32'(bus.tc_set), 32'd0);
    chk("t4_mask",     32'(bus.mask_set), 32'd0);
    tick();
    bus.HLDA = 1'b0;
    wait_idle();

    // 5: cascade ch1
    request(2'd1, 2'b11, 2'b01, 1'b0, 1'b0);
    tick();
    bus.HLDA = 1'b1;
    tick();
    chk("t5_dack", 32'(bus.dack_valid), 32'd1);
    chk("t5_dch",  32'(bus.dack_ch), 32'd1);
    chk("t5_strb", 32'({bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N}), 32'hF);
    ticks(2);
    chk("t5_upd", 32'(bus.upd_en), 32'd0);
    chk("t5_hold", 32'(bus.HRQ), 32'd1);
    bus.dreq_active = 1'b0; bus.req_valid = 1'b0;
    tick();
    chk("t5_hrq_off",  32'(bus.HRQ), 32'd0);
    chk("t5_dack_off", 32'(bus.dack_valid), 32'd0);
    bus.HLDA = 1'b0;
    wait_idle();

    // 6a: request withdrawn while waiting for HLDA
    request(2'd0, 2'b01, 2'b01, 1'b0, 1'b0);
    tick();
    chk("t6a_hrq", 32'(bus.HRQ), 32'd1);
    bus.req_valid = 1'b0;
    tick();
    chk("t6a_hrq_off", 32'(bus.HRQ), 32'd0);
    tick();
    chk("t6a_no_dack", 32'(bus.dack_valid), 32'd0);

    // 6b: asynchronous reset during S3 of a write
    load(2'd2, 16'h3000, 16'h0005, 16'h0, 16'h0);
    request(2'd2, 2'b10, 2'b01, 1'b0, 1'b0);
    tick();
    bus.HLDA = 1'b1;
    ticks(3);
    chk("t6b_s3_memw", 32'(bus.MEMW_N), 32'd0);
    #2 RESET_N = 1'b0;
    #1;
    chk("t6b_strb", 32'({bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N}), 32'hF);
    chk("t6b_hrq",  32'(bus.HRQ), 32'd0);
    chk("t6b_busy", 32'(bus.busy), 32'd0);
    bus.req_valid = 1'b0; bus.HLDA = 1'b0; bus.dreq_active = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
